// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue slice: RV32I opcode/funct3 values and ALU operation codes.
package alu_issue_pkg;

  localparam int WORD_SIZE_DEF  = 32;
  localparam int ALU_OPSIZE_DEF = 4;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // Only the base and the "alternate" (SUB/SRA) encodings are valid funct7 values.
  function automatic logic funct7_ok(input logic [6:0] f7);
    return (f7 == 7'b0000000) || (f7 == 7'b0100000);
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational translation of RV32I ALU-class fields into an ALU operation and operand pair.
module alu_issue_decode
  import alu_issue_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int ALU_OPSIZE = ALU_OPSIZE_DEF
) (
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [WORD_SIZE-1:0]  rs1_data,
  input  logic [WORD_SIZE-1:0]  rs2_data,
  input  logic [WORD_SIZE-1:0]  imm,
  input  logic [WORD_SIZE-1:0]  pc,
  output logic [ALU_OPSIZE-1:0] operation,
  output logic [WORD_SIZE-1:0]  operand_a,
  output logic [WORD_SIZE-1:0]  operand_b,
  output logic                  illegal
);

  alu_op_e op;
  logic    is_shift;

  always_comb begin
    op        = ALU_ADD;
    operand_a = '0;
    operand_b = '0;
    illegal   = 1'b0;
    is_shift  = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        operand_a = rs1_data;
        operand_b = (opcode == OPC_OP) ? rs2_data : imm;
        case (funct3)
          F3_ADD:  op = (opcode == OPC_OP && funct7[5]) ? ALU_SUB : ALU_ADD;
          F3_SLL:  begin op = ALU_SLL; is_shift = 1'b1; end
          F3_SLT:  op = ALU_SLT;
          F3_SLTU: op = ALU_SLTU;
          F3_XOR:  op = ALU_XOR;
          F3_SR:   begin op = funct7[5] ? ALU_SRA : ALU_SRL; is_shift = 1'b1; end
          F3_OR:   op = ALU_OR;
          F3_AND:  op = ALU_AND;
          default: op = ALU_ADD;
        endcase
        if (opcode == OPC_OP) illegal = !funct7_ok(funct7);
        else if (is_shift)    illegal = !funct7_ok(imm[11:5]);
        // The ALU shifts by the whole operand, so keep only the 5-bit shamt.
        if (is_shift) operand_b = {{(WORD_SIZE-5){1'b0}}, operand_b[4:0]};
      end
      OPC_LUI: operand_b = imm;
      OPC_AUIPC: begin
        operand_a = pc;
        operand_b = imm;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      op        = ALU_ADD;
      operand_a = '0;
      operand_b = '0;
    end
  end

  assign operation = ALU_OPSIZE'(op);

endmodule

// File: rtl/alu_issue.sv
// Two-stage issue/writeback wrapper around an external combinational ALU.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int ALU_OPSIZE = ALU_OPSIZE_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [6:0]            i_opcode,
  input  logic [2:0]            i_funct3,
  input  logic [6:0]            i_funct7,
  input  logic [WORD_SIZE-1:0]  i_rs1_data,
  input  logic [WORD_SIZE-1:0]  i_rs2_data,
  input  logic [WORD_SIZE-1:0]  i_imm,
  input  logic [WORD_SIZE-1:0]  i_pc,
  output logic [WORD_SIZE-1:0]  o_alu_operand_A,
  output logic [ALU_OPSIZE-1:0] o_alu_operation,
  output logic [WORD_SIZE-1:0]  o_alu_operand_B,
  input  logic [WORD_SIZE-1:0]  i_alu_result,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [WORD_SIZE-1:0]  o_result,
  output logic                  o_illegal
);

  // Handshake: a beat transfers on an edge where valid && ready; the producer holds
  // valid and payload stable until then. Upstream ready depends combinationally on i_ready.

  logic [ALU_OPSIZE-1:0] dec_operation;
  logic [WORD_SIZE-1:0]  dec_operand_a;
  logic [WORD_SIZE-1:0]  dec_operand_b;
  logic                  dec_illegal;

  logic s1_valid;
  logic s1_illegal;
  logic s2_valid;
  logic s2_free;
  logic s1_adv;
  logic up_xfer;

  alu_issue_decode #(
    .WORD_SIZE  (WORD_SIZE),
    .ALU_OPSIZE (ALU_OPSIZE)
  ) u_decode (
    .opcode    (i_opcode),
    .funct3    (i_funct3),
    .funct7    (i_funct7),
    .rs1_data  (i_rs1_data),
    .rs2_data  (i_rs2_data),
    .imm       (i_imm),
    .pc        (i_pc),
    .operation (dec_operation),
    .operand_a (dec_operand_a),
    .operand_b (dec_operand_b),
    .illegal   (dec_illegal)
  );

  assign s2_free = !s2_valid || i_ready;
  assign s1_adv  = s1_valid && s2_free;
  assign o_ready = !s1_valid || s1_adv;
  assign up_xfer = i_valid && o_ready;
  assign o_valid = s2_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid        <= 1'b0;
      s1_illegal      <= 1'b0;
      o_alu_operand_A <= '0;
      o_alu_operand_B <= '0;
      o_alu_operation <= '0;
      s2_valid        <= 1'b0;
      o_result        <= '0;
      o_illegal       <= 1'b0;
    end else begin
      if (up_xfer) begin
        s1_valid        <= 1'b1;
        s1_illegal      <= dec_illegal;
        o_alu_operand_A <= dec_operand_a;
        o_alu_operand_B <= dec_operand_b;
        o_alu_operation <= dec_operation;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_adv) begin
        s2_valid  <= 1'b1;
        o_result  <= s1_illegal ? '0 : i_alu_result;
        o_illegal <= s1_illegal;
      end else if (s2_free) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule
